// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with a one-byte holding register.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
// rx must already be synchronised to clk; there is no internal synchroniser.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       parity_error
);

  // Timer compare points: mid start bit, then one full bit period per sample.
  localparam logic [15:0] LP_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] LP_BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_timer;
  logic [15:0] w_timer_next;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic [7:0]  r_data;
  logic        r_data_valid;
  logic        r_frame_error;
  logic        r_overrun;
  logic        w_frame_done;
  logic        w_stop_low;
  logic        w_parity_bad;
`ifdef UART_RX_PARITY_EN
  logic        r_parity_bit;
  logic        w_parity_bit_next;
  logic        r_parity_error;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus bit timing, shifting and stop-bit evaluation.
  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer + 16'd1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_frame_done   = 1'b0;
    w_stop_low     = 1'b0;
    w_parity_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parity_bit_next = r_parity_bit;
`endif
    case (r_state)
      S_IDLE: begin
        w_timer_next = 16'd0;
        if (!rx) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_timer == LP_HALF_LAST) begin
          w_timer_next = 16'd0;
          // A start bit that is high again at mid-bit was a glitch.
          w_state_next = rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_timer == LP_BIT_LAST) begin
          w_timer_next   = 16'd0;
          w_shift_next   = {rx, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_next = 3'd0;
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_timer == LP_BIT_LAST) begin
          w_timer_next      = 16'd0;
          w_parity_bit_next = rx;
          w_state_next      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_timer == LP_BIT_LAST) begin
          w_timer_next = 16'd0;
`ifdef UART_RX_PARITY_EN
          // Even parity: data bits plus parity bit must XOR to zero.
          w_parity_bad = ^{r_shift, r_parity_bit};
`endif
          if (rx) begin
            w_frame_done = !w_parity_bad;
            w_state_next = S_IDLE;
          end else begin
            w_stop_low   = 1'b1;
            w_state_next = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A low stop bit means the line is not idle; wait for it to recover.
        w_timer_next = 16'd0;
        if (rx) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_timer_next = 16'd0;
      end
    endcase
  end

  // Datapath registers, holding register handshake and one-cycle flag pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer       <= 16'd0;
      r_bit_idx     <= 3'd0;
      r_shift       <= 8'h00;
      r_data        <= 8'h00;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_bit   <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      r_timer       <= w_timer_next;
      r_bit_idx     <= w_bit_idx_next;
      r_shift       <= w_shift_next;
      r_frame_error <= w_stop_low;
      r_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_bit   <= w_parity_bit_next;
      r_parity_error <= w_parity_bad;
`endif
      if (w_frame_done) begin
        // Load when empty or when the held byte leaves in this same cycle.
        if (!r_data_valid || data_ready) begin
          r_data       <= r_shift;
          r_data_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_data_valid && data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign data        = r_data;
  assign data_valid  = r_data_valid;
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_error = r_parity_error;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLKS_PER_BIT = 8.
// Frames are bit-banged onto rx; a negedge monitor records pulses and accepted
// bytes, and each test task compares them with expectations derived from the
// frame contents (good stop bit and good parity => byte delivered).
module tb_uart_rx;
  localparam int CLKS = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NDS = 10; // bit periods from start sample to stop sample
`else
  localparam int NDS = 9;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       overrun;
  logic       parity_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Monitor state
  int         fe_cnt, ov_cnt, pe_cnt, rise_cnt, vhi_cnt, rise_cyc, stab_viol;
  logic [7:0] acc_q[$];
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Timing of the last frame sent, predicted from the bit period
  int last_start;
  int last_stop_edge;

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .data(data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_error(frame_error),
    .overrun(overrun),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (parity_error) pe_cnt++;
      if (data_valid) vhi_cnt++;
      if (data_valid && !prev_valid) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      if (data_valid && data_ready) acc_q.push_back(data);
      if (prev_valid && !prev_ready && data_valid && data !== prev_data) stab_viol++;
    end
    prev_valid = data_valid;
    prev_ready = data_ready;
    prev_data  = data;
  end

  task automatic clear_mon();
    fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; rise_cnt = 0; vhi_cnt = 0;
    rise_cyc = -1; stab_viol = 0;
    acc_q.delete();
  endtask

  // Drive one frame. With ready_pulse set, data_ready is high only at the stop-sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v,
                            input logic ready_pulse);
    $display("tx byte=%h stop=%0b par=%0b ready_pulse=%0b", b, stop_v, par_v, ready_pulse);
    #1 rx = 1'b0;
    last_start = cyc;
    last_stop_edge = last_start + 1 + CLKS / 2 + CLKS * NDS;
    repeat (CLKS) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CLKS) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    #1 rx = par_v;
    repeat (CLKS) @(posedge clk);
`endif
    #1 rx = stop_v;
    for (int i = 0; i < CLKS; i++) begin
      @(posedge clk);
      #1;
      if (ready_pulse) data_ready = (cyc == last_stop_edge - 1);
    end
    rx = 1'b1;
    repeat (stop_v ? 2 : CLKS) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; data_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b expected 0", overrun); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_pe: got %b expected 0", parity_error); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    clear_mon();
    data_ready = 1'b1;
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    checks++; if (rise_cnt !== 1) begin errors++; $display("FAIL basic_rises: got %0d expected 1", rise_cnt); end
    checks++; if (vhi_cnt !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", vhi_cnt); end
    checks++; if (rise_cyc !== last_stop_edge) begin errors++; $display("FAIL basic_latency: valid at edge %0d expected %0d", rise_cyc, last_stop_edge); end
    checks++;
    if (acc_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", acc_q.size()); end
    else if (acc_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", acc_q[0]); end
    checks++; if (fe_cnt + ov_cnt + pe_cnt !== 0) begin errors++; $display("FAIL basic_flags: got fe=%0d ov=%0d pe=%0d expected 0", fe_cnt, ov_cnt, pe_cnt); end
  endtask

  task automatic test_false_start();
    clear_mon();
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (CLKS * 12) @(posedge clk);
    checks++; if (rise_cnt !== 0) begin errors++; $display("FAIL false_start_valid: got %0d rises expected 0", rise_cnt); end
    checks++; if (fe_cnt + ov_cnt + pe_cnt !== 0) begin errors++; $display("FAIL false_start_flags: got fe=%0d ov=%0d pe=%0d expected 0", fe_cnt, ov_cnt, pe_cnt); end
  endtask

  task automatic test_frame_error();
    clear_mon();
    data_ready = 1'b1;
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL fe_pulse: got %0d cycles expected 1", fe_cnt); end
    checks++; if (rise_cnt !== 0) begin errors++; $display("FAIL fe_valid: got %0d rises expected 0", rise_cnt); end
    send_frame(8'h55, 1'b1, ^8'h55, 1'b0);
    checks++;
    if (acc_q.size() != 1) begin errors++; $display("FAIL fe_next_count: got %0d expected 1", acc_q.size()); end
    else if (acc_q[0] !== 8'h55) begin errors++; $display("FAIL fe_next_data: got %h expected 55", acc_q[0]); end
    checks++; if (fe_cnt !== 1 || pe_cnt !== 0) begin errors++; $display("FAIL fe_next_flags: got fe=%0d pe=%0d expected 1/0", fe_cnt, pe_cnt); end
  endtask

  task automatic test_overrun();
    clear_mon();
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    send_frame(8'h22, 1'b1, ^8'h22, 1'b0);
    @(negedge clk);
    checks++; if (data !== 8'h11 || data_valid !== 1'b1) begin errors++; $display("FAIL ov_hold: got data=%h valid=%b expected 11/1", data, data_valid); end
    checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ov_pulse: got %0d cycles expected 1", ov_cnt); end
    @(posedge clk);
    send_frame(8'h33, 1'b1, ^8'h33, 1'b1);
    @(negedge clk);
    checks++; if (data !== 8'h33 || data_valid !== 1'b1) begin errors++; $display("FAIL ov_same_cycle: got data=%h valid=%b expected 33/1", data, data_valid); end
    checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ov_no_extra: got %0d cycles expected 1", ov_cnt); end
    checks++;
    if (acc_q.size() != 1) begin errors++; $display("FAIL ov_acc_count: got %0d expected 1", acc_q.size()); end
    else if (acc_q[0] !== 8'h11) begin errors++; $display("FAIL ov_acc_data: got %h expected 11", acc_q[0]); end
    @(posedge clk); #1 data_ready = 1'b1;
    @(posedge clk); #1 data_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (data_valid !== 1'b0 || data !== 8'h33) begin errors++; $display("FAIL ov_drain: got valid=%b data=%h expected 0/33", data_valid, data); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL ov_stable: got %0d changes expected 0", stab_viol); end
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] ff_byte;
    ff_byte = 8'hFF;
    clear_mon();
    data_ready = 1'b1;
    #1 rx = 1'b0;
    repeat (CLKS) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 rx = ff_byte[i];
      repeat (CLKS) @(posedge clk);
    end
    #1 reset = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (data !== 8'h00 || data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_data: got data=%h valid=%b expected 00/0", data, data_valid); end
    checks++; if ({frame_error, overrun, parity_error} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b expected 000", {frame_error, overrun, parity_error}); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (CLKS * 12) @(posedge clk);
    checks++; if (rise_cnt + fe_cnt + pe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL rstmid_quiet: got rises=%0d fe=%0d pe=%0d ov=%0d expected 0", rise_cnt, fe_cnt, pe_cnt, ov_cnt); end
    clear_mon();
    send_frame(8'h0F, 1'b1, ^8'h0F, 1'b0);
    checks++;
    if (acc_q.size() != 1) begin errors++; $display("FAIL rstmid_next_count: got %0d expected 1", acc_q.size()); end
    else if (acc_q[0] !== 8'h0F) begin errors++; $display("FAIL rstmid_next_data: got %h expected 0f", acc_q[0]); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    data_ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    checks++;
    if (acc_q.size() != 1) begin errors++; $display("FAIL par_good_count: got %0d expected 1", acc_q.size()); end
    else if (acc_q[0] !== 8'h07) begin errors++; $display("FAIL par_good_data: got %h expected 07", acc_q[0]); end
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    checks++; if (pe_cnt !== 1) begin errors++; $display("FAIL par_bad_pulse: got %0d cycles expected 1", pe_cnt); end
    checks++; if (rise_cnt !== 1 || fe_cnt !== 0) begin errors++; $display("FAIL par_bad_drop: got rises=%0d fe=%0d expected 1/0", rise_cnt, fe_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         fe_exp, pe_exp;
    logic [7:0] b;
    logic       stop_bad, par_bad;
    clear_mon();
    fe_exp = 0; pe_exp = 0;
    data_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom);
      stop_bad = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_PARITY_EN
      par_bad = ($urandom_range(0, 3) == 0);
`else
      par_bad = 1'b0;
`endif
      send_frame(b, !stop_bad, (^b) ^ par_bad, 1'b0);
      if (!stop_bad && !par_bad) exp_q.push_back(b);
      if (stop_bad) fe_exp++;
      if (par_bad) pe_exp++;
    end
    checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (fe_cnt !== fe_exp) begin errors++; $display("FAIL rand_fe: got %0d expected %0d", fe_cnt, fe_exp); end
    checks++; if (pe_cnt !== pe_exp) begin errors++; $display("FAIL rand_pe: got %0d expected %0d", pe_cnt, pe_exp); end
    checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL rand_ov: got %0d expected 0", ov_cnt); end
    checks++; if (vhi_cnt !== exp_q.size()) begin errors++; $display("FAIL rand_valid_cycles: got %0d expected %0d", vhi_cnt, exp_q.size()); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
